// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two ALU requesters and the shared ALU arbiter.
// Latency: none, this is wiring only.
// Backpressure: rqN_ready and rsN_ready carry the per-requester handshakes.
interface alu_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             rq0_valid;
    logic             rq0_ready;
    logic [WIDTH-1:0] rq0_a;
    logic [WIDTH-1:0] rq0_b;
    logic [2:0]       rq0_op;

    logic             rq1_valid;
    logic             rq1_ready;
    logic [WIDTH-1:0] rq1_a;
    logic [WIDTH-1:0] rq1_b;
    logic [2:0]       rq1_op;

    logic             rs0_valid;
    logic [WIDTH-1:0] rs0_result;
    logic             rs0_ready;

    logic             rs1_valid;
    logic [WIDTH-1:0] rs1_result;
    logic             rs1_ready;

    logic [CNT_W-1:0] conflict_cnt;

    // Requester side: issues operations and consumes results.
    modport master (
        output rq0_valid, rq0_a, rq0_b, rq0_op,
        output rq1_valid, rq1_a, rq1_b, rq1_op,
        output rs0_ready, rs1_ready,
        input  rq0_ready, rq1_ready,
        input  rs0_valid, rs0_result, rs1_valid, rs1_result,
        input  conflict_cnt
    );

    // Arbiter side.
    modport slave (
        input  rq0_valid, rq0_a, rq0_b, rq0_op,
        input  rq1_valid, rq1_a, rq1_b, rq1_op,
        input  rs0_ready, rs1_ready,
        output rq0_ready, rq1_ready,
        output rs0_valid, rs0_result, rs1_valid, rs1_result,
        output conflict_cnt
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one integer ALU between two requesters, with a result slot per requester.
// Latency: 1 cycle from request accept to the result appearing in that requester's slot.
// Backpressure: a full, undrained slot makes its requester ineligible; the other requester is unaffected.
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input logic          clk,
    input logic          rst,
    alu_arbiter_if.slave bus
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;

    // Shift amount is always the low five bits of b, independent of WIDTH.
    function automatic logic [WIDTH-1:0] alu_f(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [2:0]       op
    );
        logic [4:0] sh;
        sh = b[4:0];
        case (op)
            OP_ADD:  alu_f = a + b;
            OP_SUB:  alu_f = a - b;
            OP_AND:  alu_f = a & b;
            OP_OR:   alu_f = a | b;
            OP_XOR:  alu_f = a ^ b;
            OP_SLL:  alu_f = a << sh;
            OP_SRL:  alu_f = a >> sh;
            default: alu_f = $unsigned($signed(a) >>> sh);
        endcase
    endfunction

    logic             rs0_valid_q, rs0_valid_d;
    logic             rs1_valid_q, rs1_valid_d;
    logic [WIDTH-1:0] rs0_result_q, rs0_result_d;
    logic [WIDTH-1:0] rs1_result_q, rs1_result_d;
    logic             ptr_q, ptr_d;          // 0: requester 0 wins a tie
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             elig0, elig1;
    logic             gnt0, gnt1;
    logic [WIDTH-1:0] op_a, op_b;
    logic [2:0]       op_code;
    logic [WIDTH-1:0] alu_res;

    // Eligibility, round-robin grant, and a single ALU fed by the granted requester only.
    always_comb begin
        elig0   = bus.rq0_valid & (~rs0_valid_q | bus.rs0_ready);
        elig1   = bus.rq1_valid & (~rs1_valid_q | bus.rs1_ready);
        gnt0    = ~rst & elig0 & (~elig1 | ~ptr_q);
        gnt1    = ~rst & elig1 & (~elig0 |  ptr_q);
        // Non-granted operands never reach the ALU, so X there cannot leak to outputs.
        op_a    = gnt1 ? bus.rq1_a  : bus.rq0_a;
        op_b    = gnt1 ? bus.rq1_b  : bus.rq0_b;
        op_code = gnt1 ? bus.rq1_op : bus.rq0_op;
        alu_res = alu_f(op_a, op_b, op_code);
    end

    // Next-state for slots, pointer and contention counter.
    always_comb begin
        rs0_valid_d  = rs0_valid_q;
        rs1_valid_d  = rs1_valid_q;
        rs0_result_d = rs0_result_q;
        rs1_result_d = rs1_result_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;

        // Drain first; a same-cycle accept below overrides it.
        if (rs0_valid_q && bus.rs0_ready) rs0_valid_d = 1'b0;
        if (rs1_valid_q && bus.rs1_ready) rs1_valid_d = 1'b0;

        if (gnt0) begin
            rs0_valid_d  = 1'b1;
            rs0_result_d = alu_res;
            ptr_d        = 1'b1;
        end
        if (gnt1) begin
            rs1_valid_d  = 1'b1;
            rs1_result_d = alu_res;
            ptr_d        = 1'b0;
        end

        if (elig0 && elig1 && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
    end

    // State registers; reset discards any in-flight results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs0_valid_q  <= 1'b0;
            rs1_valid_q  <= 1'b0;
            rs0_result_q <= '0;
            rs1_result_q <= '0;
            ptr_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            rs0_valid_q  <= rs0_valid_d;
            rs1_valid_q  <= rs1_valid_d;
            rs0_result_q <= rs0_result_d;
            rs1_result_q <= rs1_result_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.rq0_ready    = gnt0;
    assign bus.rq1_ready    = gnt1;
    assign bus.rs0_valid    = rs0_valid_q;
    assign bus.rs1_valid    = rs1_valid_q;
    assign bus.rs0_result   = rs0_result_q;
    assign bus.rs1_result   = rs1_result_q;
    assign bus.conflict_cnt = cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter: reset, ALU ops, round-robin, hold/backpressure, saturation.
// Latency: checks results one cycle after each accept.
// Backpressure: exercises a stalled result slot while the other requester keeps flowing.
module tb_alu_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    alu_arbiter_if #(.WIDTH(32), .CNT_W(16)) bus ();
    alu_arbiter_if #(.WIDTH(32), .CNT_W(4))  bus4 ();

    alu_arbiter #(.WIDTH(32), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    alu_arbiter #(.WIDTH(32), .CNT_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Shift vectors on requester 1: a, b, op, expected result.
    logic [31:0] sh_a   [3] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0001};
    logic [31:0] sh_b   [3] = '{32'd4,         32'd4,         32'd33};
    logic [2:0]  sh_op  [3] = '{3'b111,        3'b110,        3'b101};
    logic [31:0] sh_exp [3] = '{32'hF800_0000, 32'h0800_0000, 32'h0000_0002};

    initial begin
        rst = 1'b1;
        bus.rq0_valid = 1'b0; bus.rq0_a = '0; bus.rq0_b = '0; bus.rq0_op = '0;
        bus.rq1_valid = 1'b0; bus.rq1_a = '0; bus.rq1_b = '0; bus.rq1_op = '0;
        bus.rs0_ready = 1'b0; bus.rs1_ready = 1'b0;
        bus4.rq0_valid = 1'b0; bus4.rq0_a = '0; bus4.rq0_b = '0; bus4.rq0_op = '0;
        bus4.rq1_valid = 1'b0; bus4.rq1_a = '0; bus4.rq1_b = '0; bus4.rq1_op = '0;
        bus4.rs0_ready = 1'b0; bus4.rs1_ready = 1'b0;

        // Reset state; a valid request must not be readied while in reset.
        bus.rq0_valid = 1'b1;
        #12;
        check("rst_rq0_ready",  {31'b0, bus.rq0_ready}, 32'd0);
        check("rst_rs0_valid",  {31'b0, bus.rs0_valid}, 32'd0);
        check("rst_rs1_valid",  {31'b0, bus.rs1_valid}, 32'd0);
        check("rst_rs0_result", bus.rs0_result, 32'd0);
        check("rst_rs1_result", bus.rs1_result, 32'd0);
        check("rst_cnt",        {16'b0, bus.conflict_cnt}, 32'd0);
        tick();
        rst = 1'b0;
        bus.rq0_valid = 1'b0;

        // Requester 0 alone: add then sub (wraps), 1-cycle latency.
        bus.rq0_a = 32'd5; bus.rq0_b = 32'd7; bus.rq0_op = 3'b000;
        bus.rs0_ready = 1'b1; bus.rq0_valid = 1'b1;
        #1;
        check("add_rq0_ready", {31'b0, bus.rq0_ready}, 32'd1);
        check("add_rq1_ready", {31'b0, bus.rq1_ready}, 32'd0);
        tick();
        check("add_rs0_valid", {31'b0, bus.rs0_valid}, 32'd1);
        check("add_result",    bus.rs0_result, 32'd12);
        bus.rq0_a = 32'd3; bus.rq0_b = 32'd5; bus.rq0_op = 3'b001;
        #1;
        check("sub_rq0_ready", {31'b0, bus.rq0_ready}, 32'd1);
        tick();
        check("sub_result", bus.rs0_result, 32'hFFFF_FFFE);
        bus.rq0_valid = 1'b0;
        tick();
        check("drain_rs0_valid", {31'b0, bus.rs0_valid}, 32'd0);

        // Shifts on requester 1; garbage on idle requester 0 operands.
        bus.rq0_a = 32'hDEAD_BEEF; bus.rq0_b = 32'hFFFF_FFFF; bus.rq0_op = 3'b010;
        bus.rs1_ready = 1'b1; bus.rq1_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.rq1_a = sh_a[i]; bus.rq1_b = sh_b[i]; bus.rq1_op = sh_op[i];
            tick();
            check($sformatf("shift%0d", i), bus.rs1_result, sh_exp[i]);
        end
        bus.rq1_valid = 1'b0;
        tick();
        check("drain_rs1_valid", {31'b0, bus.rs1_valid}, 32'd0);
        check("shift_cnt", {16'b0, bus.conflict_cnt}, 32'd0);

        // Both requesters continuously valid: strict alternation starting at 0.
        bus.rq0_a = 32'd10; bus.rq0_b = 32'd3; bus.rq0_op = 3'b000;
        bus.rq1_a = 32'd10; bus.rq1_b = 32'd3; bus.rq1_op = 3'b001;
        bus.rq0_valid = 1'b1; bus.rq1_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            check($sformatf("rr%0d_rq0_ready", k), {31'b0, bus.rq0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("rr%0d_rq1_ready", k), {31'b0, bus.rq1_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
            tick();
            if (k % 2 == 0) check($sformatf("rr%0d_rs0", k), bus.rs0_result, 32'd13);
            else            check($sformatf("rr%0d_rs1", k), bus.rs1_result, 32'd7);
        end
        check("rr_cnt", {16'b0, bus.conflict_cnt}, 32'd6);

        // Slot 0 stalls: after one more accept into it, only requester 1 is served.
        bus.rs0_ready = 1'b0;
        #1;
        check("stall_first_rq0_ready", {31'b0, bus.rq0_ready}, 32'd1);
        tick();
        check("stall_first_cnt", {16'b0, bus.conflict_cnt}, 32'd7);
        bus.rq0_op = 3'b011;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("stall%0d_rq0_ready", k), {31'b0, bus.rq0_ready}, 32'd0);
            check($sformatf("stall%0d_rq1_ready", k), {31'b0, bus.rq1_ready}, 32'd1);
            tick();
            check($sformatf("stall%0d_rs0_hold", k), bus.rs0_result, 32'd13);
            check($sformatf("stall%0d_cnt", k), {16'b0, bus.conflict_cnt}, 32'd7);
        end
        bus.rs0_ready = 1'b1;
        #1;
        check("refill_rq0_ready", {31'b0, bus.rq0_ready}, 32'd1);
        tick();
        check("refill_rs0_valid", {31'b0, bus.rs0_valid}, 32'd1);
        check("refill_result",    bus.rs0_result, 32'd11);
        check("refill_cnt",       {16'b0, bus.conflict_cnt}, 32'd8);

        // Mid-run asynchronous reset clears immediately; requester 0 wins afterwards.
        rst = 1'b1;
        #1;
        check("mrst_rs0_valid",  {31'b0, bus.rs0_valid}, 32'd0);
        check("mrst_rs1_valid",  {31'b0, bus.rs1_valid}, 32'd0);
        check("mrst_rs0_result", bus.rs0_result, 32'd0);
        check("mrst_cnt",        {16'b0, bus.conflict_cnt}, 32'd0);
        check("mrst_rq1_ready",  {31'b0, bus.rq1_ready}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_rq0_ready", {31'b0, bus.rq0_ready}, 32'd1);
        check("post_rst_rq1_ready", {31'b0, bus.rq1_ready}, 32'd0);
        tick();

        // Saturation of a 4-bit contention counter.
        bus4.rq0_valid = 1'b1; bus4.rq1_valid = 1'b1;
        bus4.rs0_ready = 1'b1; bus4.rs1_ready = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            check($sformatf("sat%0d", k), {28'b0, bus4.conflict_cnt}, (k < 15) ? k : 32'd15);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
